// File: rtl/alu_issue_queue.sv
// alu_issue_queue: small FIFO between upstream valid/ready and the 4-bit alu inputs.
// Latency: 1 cycle from accept (queue empty, unstalled) to issue_valid with operands on OPCODE/OP1/OP2.
// Backpressure: in_ready low when full (no pop bypass); alu_stall holds the head entry in place.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opcode,
  input  logic [3:0]    in_op1,
  input  logic [3:0]    in_op2,
  input  logic          alu_stall,
  output logic [2:0]    OPCODE,
  output logic [3:0]    OP1,
  output logic [3:0]    OP2,
  output logic          issue_valid,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [2:0] opcode;
    logic [3:0] op1;
    logic [3:0] op2;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_opcode;
  logic [3:0]    r_op1;
  logic [3:0]    r_op2;
  logic          r_issue_valid;

  logic          w_push;
  logic          w_pop;

  // Ready depends only on stored occupancy, so a same-cycle pop never frees a slot for a push.
  assign in_ready = rstn && (r_count < FULL);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_count != '0) && !alu_stall;

  assign OPCODE      = r_opcode;
  assign OP1         = r_op1;
  assign OP2         = r_op2;
  assign issue_valid = r_issue_valid;
  assign count       = r_count;

  // Entry storage; contents are don't-care after reset so no reset term is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{opcode: in_opcode, op1: in_op1, op2: in_op2};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue register: load the head on a pop, otherwise hold operands and drop the strobe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_opcode      <= '0;
      r_op1         <= '0;
      r_op2         <= '0;
      r_issue_valid <= 1'b0;
    end else if (w_pop) begin
      r_opcode      <= r_mem[r_rd_ptr].opcode;
      r_op1         <= r_mem[r_rd_ptr].op1;
      r_op2         <= r_mem[r_rd_ptr].op2;
      r_issue_valid <= 1'b1;
    end else begin
      r_issue_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Testbench for alu_issue_queue: queue-based reference model plus issue scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// The model and scoreboard update on the rising edge from the same inputs the DUT sees.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_opcode;
  logic [3:0]    in_op1;
  logic [3:0]    in_op2;
  logic          alu_stall;
  logic [2:0]    OPCODE;
  logic [3:0]    OP1;
  logic [3:0]    OP2;
  logic          issue_valid;
  logic [CW-1:0] count;

  alu_issue_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2),
    .alu_stall(alu_stall),
    .OPCODE(OPCODE), .OP1(OP1), .OP2(OP2),
    .issue_valid(issue_valid), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an ordered list of queued entries, plus what the ALU inputs should show.
  logic [10:0] m_q[$];
  logic [10:0] sb_q[$];
  logic [10:0] m_last;
  logic        m_exp_valid;
  logic        m_pushed;
  logic        m_started;
  int          m_n_pops;
  int          n_issued;

  initial begin
    m_last      = '0;
    m_exp_valid = 1'b0;
    m_pushed    = 1'b0;
    m_started   = 1'b0;
    m_n_pops    = 0;
    n_issued    = 0;
  end

  always @(posedge clk) begin
    bit can_take;
    m_started   = 1'b1;
    m_pushed    = 1'b0;
    m_exp_valid = 1'b0;
    if (!rstn) begin
      m_q.delete();
      m_last = '0;
    end else begin
      can_take = (m_q.size() < DEPTH);
      if (m_q.size() > 0 && !alu_stall) begin
        m_last      = m_q.pop_front();
        m_exp_valid = 1'b1;
        sb_q.push_back(m_last);
        m_n_pops++;
      end
      if (in_valid && can_take) begin
        m_q.push_back({in_opcode, in_op1, in_op2});
        m_pushed = 1'b1;
      end
    end
  end

  // Monitor: compare occupancy/handshake every cycle, pop the scoreboard on each issue.
  always @(negedge clk) begin
    logic [10:0] exp_e;
    if (m_started) begin
      chk("count", 32'(count), 32'(m_q.size()));
      chk("in_ready", 32'(in_ready), 32'(rstn && (m_q.size() < DEPTH)));
      chk("issue_valid", 32'(issue_valid), 32'(m_exp_valid));
      if (issue_valid === 1'b1) begin
        n_issued++;
        if (sb_q.size() == 0) begin
          chk("spurious_issue", 32'(1), 32'(0));
        end else begin
          exp_e = sb_q.pop_front();
          chk("issued_op", 32'({OPCODE, OP1, OP2}), 32'(exp_e));
        end
      end else begin
        chk("held_op", 32'({OPCODE, OP1, OP2}), 32'(m_last));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    alu_stall = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    alu_stall = 1'b0;
    for (int k = 0; k < 4 * DEPTH && m_q.size() > 0; k++) step();
    step();
  endtask

  initial begin
    int acc;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_op1    = '0;
    in_op2    = '0;
    alu_stall = 1'b0;

    // Reset then idle.
    step(); step();
    rstn = 1'b1;
    idle(3);

    // Single op.
    in_valid = 1'b1; in_opcode = 3'b001; in_op1 = 4'h3; in_op2 = 4'h5;
    step();
    idle(3);

    // Fill under stall: five offered, four accepted.
    alu_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_opcode = 3'(i); in_op1 = 4'(i + 8); in_op2 = 4'(15 - i);
      step();
    end
    in_valid = 1'b0;
    step();
    drain();

    // Wrap-around stream with stall toggling every 3 cycles.
    acc = 0;
    for (int cyc = 0; cyc < 200 && acc < 10; cyc++) begin
      alu_stall = ((cyc / 3) % 2) == 1;
      in_valid  = 1'b1;
      in_opcode = 3'(acc);
      in_op1    = 4'(acc);
      in_op2    = ~4'(acc);
      step();
      if (m_pushed) acc++;
    end
    drain();

    // Simultaneous push/pop at count == 2.
    alu_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_opcode = 3'(i + 5); in_op1 = 4'(i); in_op2 = 4'hA;
      step();
    end
    alu_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_opcode = 3'(i); in_op1 = 4'(i + 2); in_op2 = 4'(i + 9);
      step();
    end
    drain();

    // Reset mid-operation with count == 3 and in_valid held.
    alu_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_opcode = 3'(7 - i); in_op1 = 4'hC; in_op2 = 4'(i);
      step();
    end
    rstn = 1'b0; in_valid = 1'b1; in_opcode = 3'b111; in_op1 = 4'hF; in_op2 = 4'hF;
    step();
    rstn = 1'b1;
    idle(5);

    // Randomized traffic with occasional resets.
    for (int cyc = 0; cyc < 400; cyc++) begin
      rstn      = ($urandom_range(0, 63) != 0);
      in_valid  = $urandom_range(0, 1) == 1;
      alu_stall = $urandom_range(0, 3) == 0;
      in_opcode = 3'($urandom);
      in_op1    = 4'($urandom);
      in_op2    = 4'($urandom);
      step();
    end
    rstn = 1'b1;
    drain();
    idle(2);

    chk("total_issued", 32'(n_issued), 32'(m_n_pops));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
